// File: rtl/median_5x5_window_scheduler.sv
// Raster-scan read sequencer for the 5x5 median engine: issues BRAM reads, shifts pixels, flags complete windows.
// Optional stall counter output o_stall_cnt is enabled by defining MEDIAN_SCHED_PERF_EN.
module median_5x5_window_scheduler #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_median_ready,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_shift_en,
    output logic              o_window_valid,
    output logic [ROW_W-1:0]  o_center_row,
    output logic [COL_W-1:0]  o_center_col,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_state
`ifdef MEDIAN_SCHED_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] PRIME_ROW = ROW_W'(3);

    logic [2:0]        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ROW_W-1:0]  pend_row_q, pend_row_d;
    logic [COL_W-1:0]  pend_col_q, pend_col_d;
    logic              valid_q, valid_d;
    logic [ROW_W-1:0]  crow_q, crow_d;
    logic [COL_W-1:0]  ccol_q, ccol_d;

    logic stall, issue, shift, forms, at_last_pixel, start_ok;

    // Handshake: a window is transferred on any cycle where valid and ready are both high;
    // while valid is low ready is ignored, and valid/centre never change until transferred.
    assign stall         = valid_q && !i_median_ready;
    assign issue         = ((state_q == S_PRIME) || (state_q == S_STREAM)) && !stall;
    assign shift         = pend_q && !stall;
    assign forms         = shift && (pend_row_q >= ROW_W'(4)) && (pend_col_q >= COL_W'(4));
    assign at_last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign start_ok      = (state_q == S_IDLE) && i_start;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        pend_row_d = pend_row_q;
        pend_col_d = pend_col_q;
        valid_d    = valid_q;
        crow_d     = crow_q;
        ccol_d     = ccol_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_PRIME;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_PRIME: begin
                if (issue && (row_q == PRIME_ROW) && (col_q == LAST_COL)) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (issue && at_last_pixel) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pend_q && (!valid_q || i_median_ready)) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The counters hold at the final pixel so they never run past the frame.
        if (issue) begin
            pend_row_d = row_q;
            pend_col_d = col_q;
            if (!at_last_pixel) begin
                addr_d = addr_q + ADDR_W'(1);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end

        if (issue)      pend_d = 1'b1;
        else if (shift) pend_d = 1'b0;

        // A new window may replace the accepted one in the same cycle.
        if (forms) begin
            valid_d = 1'b1;
            crow_d  = pend_row_q - ROW_W'(2);
            ccol_d  = pend_col_q - COL_W'(2);
        end else if (valid_q && i_median_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            pend_col_q <= '0;
            valid_q    <= 1'b0;
            crow_q     <= '0;
            ccol_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            pend_row_q <= pend_row_d;
            pend_col_q <= pend_col_d;
            valid_q    <= valid_d;
            crow_q     <= crow_d;
            ccol_q     <= ccol_d;
        end
    end

`ifdef MEDIAN_SCHED_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    assign o_bram_en      = issue;
    assign o_bram_addr    = addr_q;
    assign o_shift_en     = shift;
    assign o_window_valid = valid_q;
    assign o_center_row   = crow_q;
    assign o_center_col   = ccol_q;
    assign o_busy         = (state_q == S_PRIME) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign o_done         = (state_q == S_DONE);
    assign o_state        = state_q;

endmodule

// File: tb/tb_median_5x5_window_scheduler.sv
// Bench for median_5x5_window_scheduler: 8x6 frame scoreboard plus a 5x5 single-window instance.
module tb_median_5x5_window_scheduler;

    localparam int W = 8;
    localparam int H = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic        bram_en, shift_en, win_valid, busy, done;
    logic [11:0] bram_addr;
    logic [2:0]  crow, ccol, state;

    logic        s5_start = 1'b0;
    logic        r5 = 1'b1;
    logic        en5, sh5, valid5, busy5, done5;
    logic [11:0] addr5;
    logic [2:0]  crow5, ccol5, state5;

`ifdef MEDIAN_SCHED_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt5;
`endif

    median_5x5_window_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_median_ready(ready),
        .o_bram_en(bram_en), .o_bram_addr(bram_addr), .o_shift_en(shift_en),
        .o_window_valid(win_valid), .o_center_row(crow), .o_center_col(ccol),
        .o_busy(busy), .o_done(done), .o_state(state)
`ifdef MEDIAN_SCHED_PERF_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    median_5x5_window_scheduler #(.IMG_W(5), .IMG_H(5), .ADDR_W(12)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s5_start), .i_median_ready(r5),
        .o_bram_en(en5), .o_bram_addr(addr5), .o_shift_en(sh5),
        .o_window_valid(valid5), .o_center_row(crow5), .o_center_col(ccol5),
        .o_busy(busy5), .o_done(done5), .o_state(state5)
`ifdef MEDIAN_SCHED_PERF_EN
        , .o_stall_cnt(stall_cnt5)
`endif
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [5:0]  exp_q[$];
    logic [11:0] addr_q[$];
    logic [5:0]  centres [8] = '{6'o22, 6'o23, 6'o24, 6'o25, 6'o32, 6'o33, 6'o34, 6'o35};

    int done_cnt = 0, target_done = 0, win_cnt = 0;
    int read36_cyc = 0, last_acc_cyc = 0;
    bit seen_first = 0, prev_stalled = 0;
    logic [2:0] prev_r, prev_c;
    int n5_reads = 0, n5_win = 0, n5_done = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_frame();
        for (int a = 0; a < W * H; a++) addr_q.push_back(12'(a));
        for (int i = 0; i < 8; i++) exp_q.push_back(centres[i]);
        seen_first  = 0;
        target_done = done_cnt + 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt < target_done && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_completes", int'(done_cnt >= target_done), 1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (state == s) begin
                hit = 1;
                break;
            end
        end
        check(name, int'(hit), 1);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [11:0] ea;
        logic [5:0]  ec;
        if (!rst_n) begin
            prev_stalled = 0;
        end else begin
            if (bram_en) begin
                check("read_expected", int'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) begin
                    ea = addr_q.pop_front();
                    check("read_addr", int'(bram_addr), int'(ea));
                end
                if (bram_addr == 12'd36) read36_cyc = cyc;
            end
            if (prev_stalled) begin
                check("held_valid", int'(win_valid), 1);
                check("held_row", int'(crow), int'(prev_r));
                check("held_col", int'(ccol), int'(prev_c));
            end
            if (win_valid && !seen_first) begin
                seen_first = 1;
                check("first_valid_latency", cyc - read36_cyc, 2);
            end
            if (win_valid && ready) begin
                check("window_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ec = exp_q.pop_front();
                    check("centre_row", int'(crow), int'(ec[5:3]));
                    check("centre_col", int'(ccol), int'(ec[2:0]));
                end
                last_acc_cyc = cyc;
                win_cnt++;
            end
            prev_stalled = win_valid && !ready;
            if (prev_stalled) begin
                check("stall_bram_en", int'(bram_en), 0);
                check("stall_shift_en", int'(shift_en), 0);
                prev_r = crow;
                prev_c = ccol;
            end
            if (done) begin
                check("done_after_last_window", cyc - last_acc_cyc, 1);
                check("no_missing_window", exp_q.size(), 0);
                check("all_reads_issued", addr_q.size(), 0);
                check("busy_low_at_done", int'(busy), 0);
                done_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (en5) begin
                check("r5_addr", int'(addr5), n5_reads);
                n5_reads++;
            end
            if (valid5) begin
                check("r5_centre_row", int'(crow5), 2);
                check("r5_centre_col", int'(ccol5), 2);
                n5_win++;
            end
            if (done5) n5_done++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        bit found;

        #12;
        check("rst_bram_en", int'(bram_en), 0);
        check("rst_addr", int'(bram_addr), 0);
        check("rst_valid", int'(win_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(state), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Frame 1: ready held high.
        w0 = win_cnt;
        start_frame();
        check("busy_after_start", int'(busy), 1);
        check("state_prime", int'(state), 1);
        wait_done(200);
        check("frame1_windows", win_cnt - w0, 8);

        // Frame 2: five-cycle stall on the first window.
        w0 = win_cnt;
        start_frame();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (win_valid) begin
                found = 1;
                break;
            end
        end
        check("stall_valid_seen", int'(found), 1);
        check("stall_first_row", int'(crow), 2);
        check("stall_first_col", int'(ccol), 2);
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready = 1'b1;
        wait_done(200);
        check("frame2_windows", win_cnt - w0, 8);
`ifdef MEDIAN_SCHED_PERF_EN
        check("stall_cnt", int'(stall_cnt), 5);
`endif

        // Frame 3: asynchronous reset in STREAM aborts the frame.
        start_frame();
        wait_state(3'd2, "reach_stream");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_bram_en", int'(bram_en), 0);
        check("abort_addr", int'(bram_addr), 0);
        check("abort_shift", int'(shift_en), 0);
        check("abort_valid", int'(win_valid), 0);
        check("abort_centre", int'({crow, ccol}), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_state", int'(state), 0);
`ifdef MEDIAN_SCHED_PERF_EN
        check("abort_stall_cnt", int'(stall_cnt), 0);
`endif
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Frame 4: restart after abort.
        w0 = win_cnt;
        start_frame();
        wait_done(200);
        check("frame4_windows", win_cnt - w0, 8);

        // Frame 5: start pulses during PRIME and DRAIN are ignored.
        w0 = win_cnt;
        start_frame();
        repeat (2) @(posedge clk);
        #1;
        check("in_prime", int'(state), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_state(3'd3, "reach_drain");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200);
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_extra_starts", int'(state), 0);
        check("not_busy_after_extra_starts", int'(busy), 0);
        check("frame5_windows", win_cnt - w0, 8);
        check("done_pulses", done_cnt, 4);

        // 5x5 image: a single window.
        @(posedge clk); #1 s5_start = 1'b1;
        @(posedge clk); #1 s5_start = 1'b0;
        for (int i = 0; i < 100 && n5_done == 0; i++) @(posedge clk);
        #1;
        check("r5_done", n5_done, 1);
        check("r5_reads", n5_reads, 25);
        check("r5_windows", n5_win, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
